ysyx_23060208_ifu_fetch: RTL and testbench

YSYX_23060208_IFU_FETCH -- requirements
Module: ysyx_23060208_ifu_fetch

---
 rtl/ysyx_23060208_ifu_fetch.sv | 137 +++++++++++++
 tb/tb_ysyx_23060208_ifu_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: single-outstanding AXI-lite-style read loop into a decode handshake.
// Optional access-fault reporting is enabled by defining YSYX_23060208_IFU_ACCESS_FAULT_EN.
module ysyx_23060208_ifu_fetch #(
  parameter int unsigned               DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] ifu_araddr,
  output logic                  ifu_arvalid,
  input  logic                  ifu_arready,
  input  logic                  ifu_rvalid,
  input  logic [1:0]            ifu_rresp,
  input  logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_rready,
  output logic                  ifu_to_idu_valid,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_inst,
  output logic [DATA_WIDTH-1:0] ifu_to_idu_pc,
  output logic                  ifu_to_idu_fault,
  input  logic                  idu_allowin,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {StAr, StR, StOut} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH-1:0]   araddr_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    discard_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   inst_q;
  logic [DATA_WIDTH-1:0]   out_pc_q;
  logic                    fault_q;

  logic                    beat_fault;
  logic [DATA_WIDTH-1:0]   beat_inst;
  logic [DATA_WIDTH-1:0]   pc_inc;

`ifdef YSYX_23060208_IFU_ACCESS_FAULT_EN
  assign beat_fault = (ifu_rresp != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^ifu_rresp;
  assign beat_fault   = 1'b0;
`endif

  assign beat_inst = beat_fault ? Nop : ifu_rdata;
  assign pc_inc    = pc_q + DATA_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StAr;
      pc_q      <= RESET_PC;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      discard_q <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      out_pc_q  <= '0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAr: begin
          // The address already on the bus stays put; a redirect only retargets the next fetch.
          if (redirect_valid) begin
            pc_q      <= redirect_pc;
            discard_q <= 1'b1;
          end
          if (arvalid_q && ifu_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StR;
          end else begin
            arvalid_q <= 1'b1;
          end
        end
        StR: begin
          if (ifu_rvalid && rready_q) begin
            rready_q <= 1'b0;
            if (discard_q || redirect_valid) begin
              discard_q <= 1'b0;
              pc_q      <= redirect_valid ? redirect_pc : pc_q;
              araddr_q  <= redirect_valid ? redirect_pc : pc_q;
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end else begin
              valid_q  <= 1'b1;
              inst_q   <= beat_inst;
              out_pc_q <= pc_q;
              fault_q  <= beat_fault;
              state_q  <= StOut;
            end
          end else if (redirect_valid) begin
            pc_q      <= redirect_pc;
            discard_q <= 1'b1;
          end
        end
        StOut: begin
          if (redirect_valid) begin
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            pc_q      <= redirect_pc;
            araddr_q  <= redirect_pc;
            arvalid_q <= 1'b1;
            state_q   <= StAr;
          end else if (valid_q && idu_allowin) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            // A faulting fetch parks here with valid low until a redirect arrives.
            if (!fault_q) begin
              pc_q      <= pc_inc;
              araddr_q  <= pc_inc;
              arvalid_q <= 1'b1;
              state_q   <= StAr;
            end
          end
        end
        default: state_q <= StAr;
      endcase
    end
  end

  assign ifu_araddr       = araddr_q;
  assign ifu_arvalid      = arvalid_q;
  assign ifu_rready       = rready_q;
  assign ifu_to_idu_valid = valid_q;
  assign ifu_to_idu_inst  = inst_q;
  assign ifu_to_idu_pc    = out_pc_q;
  assign ifu_to_idu_fault = fault_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// Directed bench for ysyx_23060208_ifu_fetch: table of fetch vectors plus hand-timed corner cases.
module tb_ysyx_23060208_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic [1:0]  ifu_rresp;
  logic [31:0] ifu_rdata;
  logic        ifu_rready;
  logic        ifu_to_idu_valid;
  logic [31:0] ifu_to_idu_inst;
  logic [31:0] ifu_to_idu_pc;
  logic        ifu_to_idu_fault;
  logic        idu_allowin;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_23060208_ifu_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_araddr       (ifu_araddr),
    .ifu_arvalid      (ifu_arvalid),
    .ifu_arready      (ifu_arready),
    .ifu_rvalid       (ifu_rvalid),
    .ifu_rresp        (ifu_rresp),
    .ifu_rdata        (ifu_rdata),
    .ifu_rready       (ifu_rready),
    .ifu_to_idu_valid (ifu_to_idu_valid),
    .ifu_to_idu_inst  (ifu_to_idu_inst),
    .ifu_to_idu_pc    (ifu_to_idu_pc),
    .ifu_to_idu_fault (ifu_to_idu_fault),
    .idu_allowin      (idu_allowin),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ar_wait;
    int          idu_wait;
    logic [31:0] rdata;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[4];

  // Issue one AR handshake at the current negedge; leaves the DUT in the read state.
  task automatic ar_hs(input string tag, input logic [31:0] exp_addr);
    chk({tag, " arvalid"}, 32'(ifu_arvalid), 32'd1);
    chk({tag, " araddr"}, ifu_araddr, exp_addr);
    ifu_arready = 1'b1;
    @(negedge clk);
    ifu_arready = 1'b0;
    chk({tag, " rready"}, 32'(ifu_rready), 32'd1);
  endtask

  task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
    ifu_rvalid = 1'b1;
    ifu_rdata  = data;
    ifu_rresp  = resp;
    @(negedge clk);
    ifu_rvalid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{ar_wait: 0, idu_wait: 0, rdata: 32'h0000_0093, exp_pc: 32'h8000_0000};
    vecs[1] = '{ar_wait: 3, idu_wait: 0, rdata: 32'h1234_5678, exp_pc: 32'h8000_0004};
    vecs[2] = '{ar_wait: 0, idu_wait: 4, rdata: 32'hDEAD_BEEF, exp_pc: 32'h8000_0008};
    vecs[3] = '{ar_wait: 0, idu_wait: 0, rdata: 32'hFFFF_FFFF, exp_pc: 32'h8000_000C};

    rst = 1'b0; ifu_arready = 1'b0; ifu_rvalid = 1'b0; ifu_rresp = 2'b00; ifu_rdata = '0;
    idu_allowin = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst arvalid", 32'(ifu_arvalid), 32'd0);
    chk("rst rready", 32'(ifu_rready), 32'd0);
    chk("rst valid", 32'(ifu_to_idu_valid), 32'd0);
    chk("rst inst", ifu_to_idu_inst, 32'd0);
    chk("rst pc", ifu_to_idu_pc, 32'd0);
    chk("rst fault", 32'(ifu_to_idu_fault), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      idu_allowin = (vecs[i].idu_wait == 0);
      for (int w = 0; w < vecs[i].ar_wait; w++) begin
        chk("ar hold arvalid", 32'(ifu_arvalid), 32'd1);
        chk("ar hold araddr", ifu_araddr, vecs[i].exp_pc);
        @(negedge clk);
      end
      ar_hs("vec", vecs[i].exp_pc);
      chk("vec single ar", 32'(ifu_arvalid), 32'd0);
      r_beat(vecs[i].rdata, 2'b00);
      for (int w = 0; w < vecs[i].idu_wait; w++) begin
        chk("stall valid", 32'(ifu_to_idu_valid), 32'd1);
        chk("stall inst", ifu_to_idu_inst, vecs[i].rdata);
        chk("stall pc", ifu_to_idu_pc, vecs[i].exp_pc);
        chk("stall no ar", 32'(ifu_arvalid), 32'd0);
        @(negedge clk);
      end
      idu_allowin = 1'b1;
      chk("vec valid", 32'(ifu_to_idu_valid), 32'd1);
      chk("vec inst", ifu_to_idu_inst, vecs[i].rdata);
      chk("vec pc", ifu_to_idu_pc, vecs[i].exp_pc);
      chk("vec fault", 32'(ifu_to_idu_fault), 32'd0);
      @(negedge clk);
      chk("vec valid drop", 32'(ifu_to_idu_valid), 32'd0);
    end

    // Redirect while waiting for read data: the beat is dropped.
    ar_hs("rd", 32'h8000_0010);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("rd still rready", 32'(ifu_rready), 32'd1);
    r_beat(32'h5555_AAAA, 2'b00);
    chk("rd dropped valid", 32'(ifu_to_idu_valid), 32'd0);
    ar_hs("rd target", 32'h8000_0100);
    r_beat(32'h0000_0113, 2'b00);
    chk("rd target pc", ifu_to_idu_pc, 32'h8000_0100);
    chk("rd target inst", ifu_to_idu_inst, 32'h0000_0113);

    // Redirect coinciding with the decode handshake: redirect target wins over pc+4.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("ro valid", 32'(ifu_to_idu_valid), 32'd0);
    chk("ro araddr", ifu_araddr, 32'h8000_0200);

    // Reset in the read state, then a stray beat after release.
    ar_hs("rs", 32'h8000_0200);
    rst = 1'b0;
    @(negedge clk);
    chk("rs rready", 32'(ifu_rready), 32'd0);
    chk("rs arvalid", 32'(ifu_arvalid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rs rel arvalid", 32'(ifu_arvalid), 32'd1);
    chk("rs rel araddr", ifu_araddr, 32'h8000_0000);
    r_beat(32'hBAD0_BAD0, 2'b00);
    chk("rs stray valid", 32'(ifu_to_idu_valid), 32'd0);
    chk("rs stray arvalid", 32'(ifu_arvalid), 32'd1);
    chk("rs stray araddr", ifu_araddr, 32'h8000_0000);

    // Error response.
    ar_hs("ft", 32'h8000_0000);
    r_beat(32'hAAAA_5555, 2'b10);
    chk("ft valid", 32'(ifu_to_idu_valid), 32'd1);
`ifdef YSYX_23060208_IFU_ACCESS_FAULT_EN
    chk("ft fault", 32'(ifu_to_idu_fault), 32'd1);
    chk("ft inst", ifu_to_idu_inst, 32'h0000_0013);
`else
    chk("ft fault", 32'(ifu_to_idu_fault), 32'd0);
    chk("ft inst", ifu_to_idu_inst, 32'hAAAA_5555);
`endif
    @(negedge clk);
    chk("ft valid drop", 32'(ifu_to_idu_valid), 32'd0);
    chk("ft fault drop", 32'(ifu_to_idu_fault), 32'd0);
`ifdef YSYX_23060208_IFU_ACCESS_FAULT_EN
    for (int w = 0; w < 3; w++) begin
      chk("ft parked", 32'(ifu_arvalid), 32'd0);
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("ft resume arvalid", 32'(ifu_arvalid), 32'd1);
    chk("ft resume araddr", ifu_araddr, 32'h8000_0300);
`else
    chk("ft next arvalid", 32'(ifu_arvalid), 32'd1);
    chk("ft next araddr", ifu_araddr, 32'h8000_0004);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
